span_painter: RTL and testbench

Parametrised successor to the single-mode span painter. Pulls 32-bit draw commands from the command FIFO/PRAM, rasterises them into per-pixel writes to the back framebuffer, and requests a buffer swap on command. Adds over the previous generation: resolution and colour-depth parameters, vertical spans, full-buffer clear, endpoint clipping and ordering, framebuffer back-pressure, and an error pulse for rejected commands.

---
 rtl/span_painter.sv | 189 ++++++++++++++++++
 tb/tb_span_painter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/span_painter.sv
// span_painter: fetches 32-bit draw commands and rasterises horizontal spans,
// vertical spans and full-buffer clears into single-pixel framebuffer writes.
// A SWAP command raises a held swap request until it is acknowledged.
module span_painter #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               empty,
  output logic               re,
  input  logic [31:0]        PRAMdata,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] data,
  output logic               we,
  input  logic               fb_ready,
  output logic               swapBuffersCommand,
  input  logic               swapBuffers,
  output logic               busy,
  output logic               cmd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    DRAW   = 3'd4,
    SWAP   = 3'd5
  } state_t;

  localparam logic [1:0] OP_HSPAN = 2'b00;
  localparam logic [1:0] OP_VSPAN = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  // Largest legal x / y, kept 9 bits wide so a 256-pixel axis still fits.
  localparam logic [8:0]        H_MAX    = 9'(H_RES - 1);
  localparam logic [8:0]        V_MAX    = 9'(V_RES - 1);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(H_RES * V_RES - 1);

  state_t state, state_nxt;

  // Command fields
  logic [1:0]         op;
  logic [COLOR_W-1:0] col;
  logic [7:0]         fix;
  logic [7:0]         pa;
  logic [7:0]         pb;
  logic [7:0]         lo;
  logic [7:0]         hi;
  logic [7:0]         hi_h;
  logic [7:0]         hi_v;
  logic               unused_col;

  // Decode results, valid while state == DECODE
  logic               dec_rej;
  logic               dec_vert;
  logic [ADDR_W-1:0]  dec_base;
  logic [ADDR_W-1:0]  dec_last;

  // Span walk state
  logic [ADDR_W-1:0]  cnt;
  logic               vert;
  logic               accept;

  // Clamp the far end of a span to the last legal coordinate on its axis.
  function automatic logic [7:0] clamp_hi(input logic [7:0] v, input logic [8:0] lim);
    if ({1'b0, v} > lim) return lim[7:0];
    return v;
  endfunction

  assign op         = PRAMdata[31:30];
  assign col        = PRAMdata[24 +: COLOR_W];
  assign fix        = PRAMdata[23:16];
  assign pa         = PRAMdata[15:8];
  assign pb         = PRAMdata[7:0];
  assign unused_col = ^PRAMdata[29:24];

  // Endpoints are ordered so spans are always walked in ascending address order.
  assign lo   = (pa <= pb) ? pa : pb;
  assign hi   = (pa <= pb) ? pb : pa;
  assign hi_h = clamp_hi(hi, H_MAX);
  assign hi_v = clamp_hi(hi, V_MAX);

  assign accept = we & fb_ready;

  // Command decode: reject off-screen spans, compute base address and pixel count.
  always_comb begin
    dec_rej  = 1'b0;
    dec_vert = 1'b0;
    dec_base = '0;
    dec_last = '0;
    case (op)
      OP_HSPAN: begin
        if (({1'b0, fix} > V_MAX) || ({1'b0, lo} > H_MAX)) begin
          dec_rej = 1'b1;
        end else begin
          dec_base = ADDR_W'(fix) * H_STEP + ADDR_W'(lo);
          dec_last = ADDR_W'(hi_h - lo);
        end
      end
      OP_VSPAN: begin
        dec_vert = 1'b1;
        if (({1'b0, fix} > H_MAX) || ({1'b0, lo} > V_MAX)) begin
          dec_rej = 1'b1;
        end else begin
          dec_base = ADDR_W'(lo) * H_STEP + ADDR_W'(fix);
          dec_last = ADDR_W'(hi_v - lo);
        end
      end
      OP_CLEAR: begin
        dec_base = '0;
        dec_last = PIX_LAST;
      end
      default: begin
        dec_rej = 1'b0;
      end
    endcase
  end

  // Next-state logic for the fetch / decode / draw / swap sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!empty) state_nxt = FETCH;
      FETCH:  state_nxt = WAIT;
      WAIT:   state_nxt = DECODE;
      DECODE: begin
        if (op == 2'b11)  state_nxt = SWAP;
        else if (dec_rej) state_nxt = IDLE;
        else              state_nxt = DRAW;
      end
      DRAW:   if (accept && (cnt == '0)) state_nxt = IDLE;
      SWAP:   if (swapBuffers) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Registered control outputs, all derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      re                 <= 1'b0;
      we                 <= 1'b0;
      swapBuffersCommand <= 1'b0;
      busy               <= 1'b0;
      cmd_err            <= 1'b0;
    end else begin
      re                 <= (state_nxt == FETCH);
      we                 <= (state_nxt == DRAW);
      swapBuffersCommand <= (state_nxt == SWAP);
      busy               <= (state_nxt != IDLE);
      cmd_err            <= (state == DECODE) && (op != 2'b11) && dec_rej;
    end
  end

  // Pixel address and colour: loaded at decode, advanced on each accepted write,
  // frozen while the framebuffer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      data <= '0;
    end else if ((state == DECODE) && (op != 2'b11) && !dec_rej) begin
      addr <= dec_base;
      data <= col;
    end else if ((state == DRAW) && accept && (cnt != '0)) begin
      addr <= addr + (vert ? H_STEP : ADDR_W'(1));
    end
  end

  // Remaining-pixel counter and step direction for the span being drawn.
  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      cnt  <= dec_last;
      vert <= dec_vert;
    end else if ((state == DRAW) && accept && (cnt != '0)) begin
      cnt  <= cnt - ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_span_painter.sv
// Directed bench for span_painter: spans, clipping, rejects, back-pressure,
// swap handshake, clear and reset during a clear.
module tb_span_painter;

  logic        clk;
  logic        reset;
  logic        empty;
  logic        re;
  logic [31:0] PRAMdata;
  logic [14:0] addr;
  logic [2:0]  data;
  logic        we;
  logic        fb_ready;
  logic        swapBuffersCommand;
  logic        swapBuffers;
  logic        busy;
  logic        cmd_err;

  span_painter #(.H_RES(160), .V_RES(120), .COLOR_W(3), .ADDR_W(15)) dut (
    .clk(clk), .reset(reset), .empty(empty), .re(re), .PRAMdata(PRAMdata),
    .addr(addr), .data(data), .we(we), .fb_ready(fb_ready),
    .swapBuffersCommand(swapBuffersCommand), .swapBuffers(swapBuffers),
    .busy(busy), .cmd_err(cmd_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int re_cnt = 0;
  int re_cyc = 0;
  int err_cnt = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int st, en, ha, hd, hold_bad, r0, r1, e0, nbad, k_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Record every accepted write, read strobe and error pulse mid-cycle.
  always @(negedge clk) begin
    if (re) begin re_cnt++; re_cyc = cyc; end
    if (cmd_err) err_cnt++;
    if (we && fb_ready) begin
      wa.push_back(int'(addr));
      wd.push_back(int'(data));
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input int op, input int c, input int f, input int a, input int b);
    return {2'(op), 6'(c), 8'(f), 8'(a), 8'(b)};
  endfunction

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  // Offer one command, wait for its fetch, then for the painter to go idle.
  task automatic run_cmd(input logic [31:0] w, output int s, output int e);
    int rr;
    rr = re_cnt;
    PRAMdata = w;
    empty = 1'b0;
    s = cyc;
    for (int k = 0; k < 20 && re_cnt == rr; k++) tick();
    empty = 1'b1;
    check("fetch_seen", int'(re_cnt != rr), 1);
    for (int k = 0; k < 30000 && busy; k++) tick();
    check("idle_reached", int'(busy), 0);
    e = cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic check_span(input string tag, input int base, input int step,
                            input int n, input int c, input bit consec);
    check({tag, "_count"}, wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa[i], base + i * step);
      check($sformatf("%s_data%0d", tag, i), wd[i], c);
      if (consec && i > 0) check($sformatf("%s_cyc%0d", tag, i), wc[i], wc[i-1] + 1);
    end
  endtask

  initial begin
    reset = 1'b1; empty = 1'b1; fb_ready = 1'b1; swapBuffers = 1'b0; PRAMdata = '0;
    tick(); tick();
    check("rst_re", int'(re), 0);
    check("rst_we", int'(we), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_data", int'(data), 0);
    check("rst_swapcmd", int'(swapBuffersCommand), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(cmd_err), 0);
    reset = 1'b0;
    tick();

    // HSPAN y=2, 5..8, colour 3
    clr();
    run_cmd(mk(0, 3, 2, 5, 8), st, en);
    check_span("h1", 325, 1, 4, 3, 1'b1);
    check("h1_re_cyc", re_cyc, st + 1);
    if (wc.size() > 0) check("h1_first_we", wc[0], st + 4);
    if (wc.size() == 4) check("h1_idle_after", en, wc[3] + 1);
    check("h1_we_low", int'(we), 0);

    // VSPAN x=10, 118..200 clipped to 119
    clr();
    run_cmd(mk(1, 1, 10, 118, 200), st, en);
    check_span("v1", 18890, 160, 2, 1, 1'b1);

    // Endpoints given in reverse order
    clr();
    run_cmd(mk(0, 6, 0, 9, 4), st, en);
    check_span("hswap", 4, 1, 6, 6, 1'b1);

    // Single pixel and right-edge clip
    clr();
    run_cmd(mk(0, 7, 1, 7, 7), st, en);
    check_span("hone", 167, 1, 1, 7, 1'b1);
    clr();
    run_cmd(mk(0, 2, 119, 159, 255), st, en);
    check_span("hclip", 19199, 1, 1, 2, 1'b1);

    // Back-pressure: stall 3 cycles when pixel 4 is presented
    clr();
    hold_bad = 0;
    fork
      run_cmd(mk(0, 2, 5, 0, 7), st, en);
      begin
        for (int k = 0; k < 40 && wa.size() < 4; k++) tick();
        fb_ready = 1'b0;
        ha = int'(addr);
        hd = int'(data);
        repeat (3) begin
          tick();
          if (int'(addr) != ha || int'(data) != hd || !we) hold_bad++;
        end
        fb_ready = 1'b1;
      end
    join
    check("bp_hold", hold_bad, 0);
    check("bp_held_addr", ha, 804);
    check_span("bp", 800, 1, 8, 2, 1'b0);
    if (wc.size() >= 5) check("bp_gap", wc[4] - wc[3], 4);

    // Rejected commands: off-screen row, off-screen column, start past edge
    e0 = err_cnt; clr();
    run_cmd(mk(0, 1, 120, 0, 5), st, en);
    check("rej_y_err", err_cnt - e0, 1);
    check("rej_y_writes", wa.size(), 0);
    e0 = err_cnt; clr();
    run_cmd(mk(1, 1, 200, 0, 5), st, en);
    check("rej_x_err", err_cnt - e0, 1);
    check("rej_x_writes", wa.size(), 0);
    e0 = err_cnt; clr();
    run_cmd(mk(0, 1, 0, 200, 170), st, en);
    check("rej_lo_err", err_cnt - e0, 1);
    check("rej_lo_writes", wa.size(), 0);
    e0 = err_cnt; clr();
    run_cmd(mk(0, 4, 3, 1, 2), st, en);
    check("after_rej_err", err_cnt - e0, 0);
    check_span("after_rej", 481, 1, 2, 4, 1'b1);

    // SWAP held off 10 cycles with commands waiting
    clr();
    r0 = re_cnt;
    PRAMdata = mk(3, 0, 0, 0, 0);
    empty = 1'b0;
    for (int k = 0; k < 20 && re_cnt == r0; k++) tick();
    for (int k = 0; k < 10 && !swapBuffersCommand; k++) tick();
    check("swap_req", int'(swapBuffersCommand), 1);
    PRAMdata = mk(0, 5, 3, 0, 0);
    r1 = re_cnt;
    hold_bad = 0;
    repeat (10) begin
      tick();
      if (!swapBuffersCommand) hold_bad++;
    end
    check("swap_hold", hold_bad, 0);
    check("swap_no_fetch", re_cnt - r1, 0);
    swapBuffers = 1'b1;
    k_ack = cyc;
    tick();
    swapBuffers = 1'b0;
    check("swap_drop", int'(swapBuffersCommand), 0);
    for (int k = 0; k < 20 && re_cnt == r1; k++) tick();
    empty = 1'b1;
    check("swap_refetch", re_cyc, k_ack + 2);
    for (int k = 0; k < 50 && busy; k++) tick();
    @(negedge clk);
    #1;
    check_span("post_swap", 480, 1, 1, 5, 1'b1);

    // Full clear, colour 5
    clr();
    run_cmd(mk(2, 5, 0, 0, 0), st, en);
    check("clr_count", wa.size(), 19200);
    nbad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != i || wd[i] != 5 || (i > 0 && wc[i] != wc[i-1] + 1)) nbad++;
    check("clr_bad_pixels", nbad, 0);

    // Clear interrupted by reset after 1000 writes
    clr();
    r0 = re_cnt;
    PRAMdata = mk(2, 5, 0, 0, 0);
    empty = 1'b0;
    for (int k = 0; k < 20 && re_cnt == r0; k++) tick();
    empty = 1'b1;
    for (int k = 0; k < 1100 && wa.size() < 1000; k++) tick();
    check("clr2_reached", wa.size(), 1000);
    reset = 1'b1;
    tick();
    check("rst2_we", int'(we), 0);
    check("rst2_re", int'(re), 0);
    check("rst2_addr", int'(addr), 0);
    check("rst2_data", int'(data), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_swapcmd", int'(swapBuffersCommand), 0);
    check("rst2_err", int'(cmd_err), 0);
    reset = 1'b0;
    tick();

    // Normal operation after the abort
    clr();
    run_cmd(mk(1, 3, 0, 0, 2), st, en);
    check_span("recover", 0, 160, 3, 3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $finish;
  end

endmodule
